// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant. The grant is held until
// done, a dropped holder request, or MAX_HOLD cycles; the pointer then advances.
module onehot_rr_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic                 done,
   output logic [N-1:0]         gnt,
   output logic                 gnt_valid,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 timeout
);

   localparam int IW = $clog2(N);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t         state_reg,   state_next;
   logic [N-1:0]   gnt_reg,     gnt_next;
   logic [IW-1:0]  id_reg,      id_next;
   logic [IW-1:0]  ptr_reg,     ptr_next;
   logic [7:0]     hold_reg,    hold_next;
   logic           timeout_reg, timeout_next;

   logic [IW-1:0]  cand_idx [N];
   logic           pick_valid;
   logic [IW-1:0]  pick_id;
   logic           holder_req;
   logic           expire;

   // cand_idx[gi] is the requester examined gi-th in the circular search from ptr.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_cand
         logic [IW:0] sum;
         assign sum          = {1'b0, ptr_reg} + (IW+1)'(gi);
         assign cand_idx[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
      end
   endgenerate

   // Scan from the far end so the nearest set request is the last one written.
   always_comb begin
      pick_valid = 1'b0;
      pick_id    = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (req[cand_idx[i]]) begin
            pick_valid = 1'b1;
            pick_id    = cand_idx[i];
         end
      end
   end

   assign holder_req = req[id_reg];
   assign expire     = (hold_reg == 8'(MAX_HOLD));

   always_comb begin
      state_next   = state_reg;
      gnt_next     = gnt_reg;
      id_next      = id_reg;
      ptr_next     = ptr_reg;
      hold_next    = hold_reg;
      timeout_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pick_valid) begin
               state_next = GRANT;
               gnt_next   = {{(N-1){1'b0}}, 1'b1} << pick_id;
               id_next    = pick_id;
               hold_next  = 8'd1;
            end
         end
         GRANT: begin
            if (done || !holder_req || expire) begin
               state_next   = IDLE;
               gnt_next     = '0;
               id_next      = '0;
               hold_next    = '0;
               ptr_next     = (id_reg == IW'(N-1)) ? '0 : id_reg + 1'b1;
               // Only a pure expiry counts as a timeout; done wins a tie.
               timeout_next = expire && !done && holder_req;
            end else begin
               hold_next = hold_reg + 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
            gnt_next   = '0;
            id_next    = '0;
            hold_next  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         gnt_reg     <= '0;
         id_reg      <= '0;
         ptr_reg     <= '0;
         hold_reg    <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         gnt_reg     <= gnt_next;
         id_reg      <= id_next;
         ptr_reg     <= ptr_next;
         hold_reg    <= hold_next;
         timeout_reg <= timeout_next;
      end
   end

   assign gnt       = gnt_reg;
   assign gnt_valid = |gnt_reg;
   assign gnt_id    = id_reg;
   assign timeout   = timeout_reg;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Bench for onehot_rr_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against an integer-level arbitration model.
module tb_onehot_rr_arbiter;

   localparam int N        = 4;
   localparam int MAX_HOLD = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic         done;
   logic [N-1:0] gnt;
   logic         gnt_valid;
   logic [1:0]   gnt_id;
   logic         timeout;

   int total = 0;
   int bad   = 0;

   // Model state: who owns the grant, for how many cycles, and where search starts.
   int m_busy, m_owner, m_cycles, m_ptr, m_to;

   onehot_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      int c;
      int found;
      if (rst) begin
         m_busy = 0; m_owner = 0; m_cycles = 0; m_ptr = 0; m_to = 0;
      end else if (m_busy == 0) begin
         m_to  = 0;
         found = 0;
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (found == 0 && req[c]) begin
               found = 1; m_owner = c;
            end
         end
         if (found != 0) begin
            m_busy = 1; m_cycles = 1;
         end
      end else begin
         if (done || !req[m_owner] || m_cycles == MAX_HOLD) begin
            m_to   = (!done && req[m_owner]) ? 1 : 0;
            m_ptr  = (m_owner + 1) % N;
            m_busy = 0; m_owner = 0; m_cycles = 0;
         end else begin
            m_cycles++;
            m_to = 0;
         end
      end
   endtask

   // One clock: advance the model with the inputs sampled at the edge, then check.
   task automatic step();
      logic [N-1:0] m_gnt;
      @(posedge clk);
      model_edge();
      #1;
      m_gnt = (m_busy != 0) ? (N'(1) << m_owner) : '0;
      chk("gnt",       gnt,       m_gnt);
      chk("gnt_id",    gnt_id,    (m_busy != 0) ? m_owner : 0);
      chk("gnt_valid", gnt_valid, m_busy != 0);
      chk("timeout",   timeout,   m_to);
      chk("no_x",      $isunknown({gnt, gnt_valid, gnt_id, timeout}), 0);
      chk("onehot0",   $onehot0(gnt), 1);
      chk("valid_or",  gnt_valid, |gnt);
      chk("id_cons",   gnt_valid ? gnt[gnt_id] : (gnt_id == 2'd0), 1);
   endtask

   task automatic reset_dut();
      rst = 1'b1; req = '0; done = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = '0; done = 1'b0;
      #1;
      reset_dut();
      chk("rst_gnt",     gnt,     4'b0000);
      chk("rst_timeout", timeout, 1'b0);

      // Basic grant and rotation to the next requester
      req = 4'b0110;
      step(); chk("basic_first", gnt, 4'b0010);
      done = 1'b1; step(); done = 1'b0;
      chk("basic_gap", gnt, 4'b0000);
      step(); chk("basic_second", gnt, 4'b0100);
      $display("basic: grants 0010 then 0100");

      // Holder drops its request: ptr moves to 3, then wraps to 0
      req = 4'b1001;
      step(); chk("drop_release", gnt, 4'b0000);
      step(); chk("wrap_idx3", gnt, 4'b1000);
      done = 1'b1; step(); done = 1'b0;
      chk("wrap_gap", gnt, 4'b0000);
      step(); chk("wrap_to0", gnt, 4'b0001);
      $display("wrap: grants 1000 then 0001");

      // Pure expiry: 8 grant cycles, timeout pulse, regrant
      reset_dut();
      req = 4'b0001;
      for (int i = 1; i <= MAX_HOLD; i++) begin
         step(); chk($sformatf("hold_c%0d", i), gnt, 4'b0001);
      end
      step(); chk("to_gnt", gnt, 4'b0000); chk("to_pulse", timeout, 1'b1);
      step(); chk("to_regrant", gnt, 4'b0001); chk("to_cleared", timeout, 1'b0);
      $display("timeout: 8 hold cycles, pulse, regrant");

      // done coincides with the 8th hold cycle: no timeout
      for (int i = 2; i <= MAX_HOLD; i++) step();
      done = 1'b1; step(); done = 1'b0;
      chk("tie_gnt", gnt, 4'b0000); chk("tie_no_to", timeout, 1'b0);
      $display("tie: done wins over expiry");

      // Reset in the 3rd grant cycle, then arbitrate from ptr 0
      reset_dut();
      step();
      req = 4'b0100;
      step(); step(); step();
      chk("mid_pre", gnt, 4'b0100);
      rst = 1'b1; req = 4'b1111;
      step();
      chk("mid_gnt", gnt, 4'b0000); chk("mid_id", gnt_id, 2'd0);
      chk("mid_valid", gnt_valid, 1'b0); chk("mid_to", timeout, 1'b0);
      rst = 1'b0;
      step(); chk("post_rst", gnt, 4'b0001);
      $display("reset mid-grant: aborted, then grant 0001");

      // Random traffic
      for (int cyc = 0; cyc < 10000; cyc++) begin
         req  = N'($urandom);
         if ($urandom_range(0, 3) == 0) req = req | (N'(1) << $urandom_range(0, N-1));
         done = ($urandom_range(0, 5) == 0);
         rst  = ($urandom_range(0, 299) == 0);
         step();
      end
      $display("random: 10000 cycles");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/onehot_rr_arbiter.md
ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

Interface
REQ-001: Parameter N, default 4, is the number of requesters; legal range is 2..16.
REQ-002: Parameter MAX_HOLD, default 8, is the maximum number of consecutive cycles one grant may be held; legal range is 1..255.
REQ-003: Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-004: Port rst, input, 1 bit, is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005: Port req, input, N bits, carries one request bit per requester; requests are level-sensitive.
REQ-006: Port done, input, 1 bit, is a release pulse from the current grant holder.
REQ-007: Port gnt, output, N bits, is the registered grant vector; it SHALL be one-hot or all-zero in every cycle and SHALL never contain X or Z.
REQ-008: Port gnt_valid, output, 1 bit, SHALL equal the OR-reduction of gnt.
REQ-009: Port gnt_id, output, clog2(N) bits, is the binary index of the set gnt bit; it is 0 when gnt_valid is 0.
REQ-010: Port timeout, output, 1 bit, is a one-cycle pulse on a forced (MAX_HOLD) release.

Function
REQ-011: The FSM SHALL have two states: IDLE and GRANT.
REQ-012: In IDLE with req nonzero at edge k, gnt SHALL be set after edge k to the first set req bit, searching circularly upward from index ptr, and the FSM SHALL enter GRANT; latency is 1 cycle.
REQ-013: In IDLE with req all-zero, gnt SHALL remain 0, the FSM SHALL stay in IDLE, and ptr SHALL be unchanged.
REQ-014: In GRANT, gnt SHALL hold its value and a hold counter SHALL increment by 1 per cycle, starting at 1 in the first grant cycle.
REQ-015: Release occurs at the first edge in GRANT where any of the following holds: done=1, req[gnt_id]=0, or the hold counter equals MAX_HOLD.
REQ-016: On release, gnt SHALL clear to 0, the FSM SHALL return to IDLE, and ptr SHALL become (gnt_id+1) mod N; a one-cycle idle gap always separates consecutive grants.
REQ-017: timeout SHALL pulse high for exactly the cycle after a release caused solely by the hold counter reaching MAX_HOLD.
REQ-018: If done and hold-counter expiry coincide, the release SHALL count as done-caused, and timeout SHALL stay 0.
REQ-019: The ptr wrap-around SHALL be modulo N, so N-1 wraps to 0.
REQ-020: The hold counter SHALL be 8 bits wide and SHALL never exceed MAX_HOLD.
REQ-021: done asserted in IDLE SHALL be ignored.
REQ-022: Changes to requesters other than the holder during GRANT SHALL have no effect until the next IDLE cycle.

Reset
REQ-023: While rst=1 at an edge, after that edge: gnt=0, gnt_valid=0, gnt_id=0, timeout=0, ptr=0, hold counter=0, and the FSM is in IDLE.
REQ-024: A reset asserted mid-grant SHALL abort the grant with no timeout pulse, and ptr SHALL return to 0.
REQ-025: In the first edge after rst deasserts, the block SHALL arbitrate normally.

Verification
REQ-026: Basic grant with N=4: after reset, drive req=4'b0110 and hold it. Required: gnt=4'b0010 one cycle later; pulse done; then gnt=0 for one cycle; then gnt=4'b0100.
REQ-027: Wrap-around: req=4'b1001 held, grant index 3 first reached via ptr=3. Required: after done, the next grant is gnt=4'b0001.
REQ-028: Timeout with MAX_HOLD=8: req=4'b0001 held, done never asserted. Required: gnt=4'b0001 for exactly 8 cycles, then gnt=0 with timeout=1 for one cycle, then regrant of 4'b0001.
REQ-029: Coincident done and expiry: done asserted in the 8th hold cycle. Required: release with timeout=0.
REQ-030: Reset mid-grant: rst=1 during the 3rd cycle of gnt=4'b0100. Required: all outputs 0 after that edge; with req=4'b1111 after reset, the grant is 4'b0001.
REQ-031: Random req/done stimulus for 10k cycles with concurrent checks: gnt is one-hot or zero, contains no X, and gnt_valid and gnt_id are consistent with gnt; all checks must pass.
